spi_tx_feeder: RTL and testbench

SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

---
 rtl/spi_tx_feeder.sv | 123 ++++++++++++
 tb/tb_spi_tx_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: byte FIFO feeding an SPI transmitter one byte at a time, with chip-select framing.
// Define SPI_FEEDER_CS_EN to generate cs_n with a CS_HOLD tail; otherwise cs_n is tied high.
module spi_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CS_HOLD    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx_rd_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_sent,
    output logic                  busy,
    output logic                  cs_n
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
`ifdef SPI_FEEDER_CS_EN
    localparam int CW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SENT, ST_CS_HOLD} state_t;
    logic [CW-1:0] hold_q, hold_d;
    logic          cs_n_q;
`else
    typedef enum logic {ST_IDLE, ST_WAIT_SENT} state_t;
`endif
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, empty_q, overflow_q;
    logic                  tx_rd_en_q, busy_q;
    logic [7:0]            tx_data_q;
    state_t                state_q, state_d;
    logic                  push, pop;

    // Only WAIT_SENT needs tx_sent to release the next byte; IDLE and CS_HOLD issue as soon as data exists.
    always_comb begin
        push    = wr_en && !full_q;
        pop     = !empty_q && (state_q != ST_WAIT_SENT || tx_sent);
        level_d = level_q + LW'(push) - LW'(pop);
        state_d = state_q;
`ifdef SPI_FEEDER_CS_EN
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: state_d = pop ? ST_WAIT_SENT : ST_IDLE;
            ST_WAIT_SENT: begin
                state_d = (tx_sent && !pop) ? ST_CS_HOLD : ST_WAIT_SENT;
                hold_d  = (tx_sent && !pop) ? CW'(CS_HOLD - 1) : hold_q;
            end
            default: begin
                state_d = pop ? ST_WAIT_SENT : (hold_q == '0) ? ST_IDLE : ST_CS_HOLD;
                hold_d  = (pop || hold_q == '0) ? hold_q : hold_q - 1'b1;
            end
        endcase
`else
        case (state_q)
            ST_IDLE: state_d = pop ? ST_WAIT_SENT : ST_IDLE;
            default: state_d = (tx_sent && !pop) ? ST_IDLE : ST_WAIT_SENT;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + DEPTH_LOG2'(push);
            rd_ptr_q   <= rd_ptr_q + DEPTH_LOG2'(pop);
            level_q    <= level_d;
            full_q     <= level_d == LW'(DEPTH);
            empty_q    <= level_d == '0;
            overflow_q <= wr_en && full_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_rd_en_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
`ifdef SPI_FEEDER_CS_EN
            hold_q     <= '0;
            cs_n_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            tx_rd_en_q <= pop;
            tx_data_q  <= pop ? mem_q[rd_ptr_q] : tx_data_q;
            busy_q     <= state_d != ST_IDLE;
`ifdef SPI_FEEDER_CS_EN
            hold_q     <= hold_d;
            cs_n_q     <= state_d == ST_IDLE;
`endif
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_rd_en = tx_rd_en_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
`ifdef SPI_FEEDER_CS_EN
    assign cs_n     = cs_n_q;
`else
    assign cs_n     = 1'b1;
`endif
endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb_spi_tx_feeder: directed stimulus with a byte scoreboard checked whenever tx_rd_en is seen.
module tb_spi_tx_feeder;
    localparam int HOLD = 8;
`ifdef SPI_FEEDER_CS_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, tx_sent = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, overflow, tx_rd_en, busy, cs_n;
    logic [4:0] level;
    logic [7:0] tx_data;
    int         total = 0, bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_tx_feeder #(.DEPTH_LOG2(4), .CS_HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_rd_en(tx_rd_en), .tx_data(tx_data), .tx_sent(tx_sent),
        .busy(busy), .cs_n(cs_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && tx_rd_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx: got %0h want none", tx_data);
            end else begin
                chk("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit expect_out);
        wr_en = 1'b1;
        wr_data = d;
        if (expect_out) exp_q.push_back(d);
        tick;
        wr_en = 1'b0;
    endtask

    task automatic sent;
        tx_sent = 1'b1;
        tick;
        tx_sent = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            tick;
            n++;
        end
        chk(nm, busy, 0);
        chk({nm, "_cs"}, cs_n, 1);
    endtask

    task automatic rst_vals(input string nm);
        chk({nm, "_level"}, level, 0);
        chk({nm, "_empty"}, empty, 1);
        chk({nm, "_full"}, full, 0);
        chk({nm, "_ovf"}, overflow, 0);
        chk({nm, "_rd"}, tx_rd_en, 0);
        chk({nm, "_data"}, tx_data, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_cs"}, cs_n, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 rst_vals("reset");
        tick;
        rst_n = 1'b1;
        tick;
        // single byte and first-byte latency
        wr(8'hA5, 1);
        chk("lat_level", level, 1);
        chk("lat_empty", empty, 0);
        chk("lat_rd_early", tx_rd_en, 0);
        tick;
        chk("lat_rd", tx_rd_en, 1);
        chk("single_busy", busy, 1);
        chk("single_cs", cs_n, !CS_ON);
        chk("single_level", level, 0);
        tick;
        chk("rd_pulse", tx_rd_en, 0);
        chk("data_hold", tx_data, 8'hA5);
        sent;
`ifdef SPI_FEEDER_CS_EN
        begin
            int n = 0;
            chk("hold_start_cs", cs_n, 0);
            chk("hold_start_busy", busy, 1);
            while (cs_n === 1'b0 && n < 40) begin
                tick;
                n++;
            end
            chk("hold_len", n, HOLD);
            chk("hold_end_busy", busy, 0);
        end
`else
        chk("idle_after_sent", busy, 0);
        chk("idle_cs", cs_n, 1);
`endif
        sent;
        chk("sent_ignored_rd", tx_rd_en, 0);
        chk("sent_ignored_busy", busy, 0);
        // burst of four back-to-back writes
        wr(8'h01, 1);
        wr(8'h02, 1);
        chk("push_pop_level", level, 1);
        wr(8'h03, 1);
        wr(8'h04, 1);
        chk("burst_level", level, 3);
        for (int i = 0; i < 3; i++) begin
            sent;
            chk("burst_next", tx_rd_en, 1);
            chk("burst_cs", cs_n, !CS_ON);
            tick;
            chk("burst_rd_low", tx_rd_en, 0);
        end
        sent;
        wait_idle("burst_idle");
`ifdef SPI_FEEDER_CS_EN
        // re-arm during the chip-select tail
        wr(8'hB1, 1);
        tick;
        chk("rearm_first", tx_rd_en, 1);
        sent;
        repeat (4) tick;
        chk("rearm_cs_mid", cs_n, 0);
        wr(8'hC3, 1);
        chk("rearm_cs_wr", cs_n, 0);
        tick;
        chk("rearm_issue", tx_rd_en, 1);
        chk("rearm_cs", cs_n, 0);
        tick;
        sent;
        wait_idle("rearm_idle");
`endif
        // fill with a stalled transmitter
        for (int i = 0; i < 17; i++) begin
            wr(8'(8'h10 + i), 1);
            if (i == 15) begin
                chk("fill15_level", level, 15);
                chk("fill15_full", full, 0);
            end
        end
        chk("fill_level", level, 16);
        chk("fill_full", full, 1);
        chk("fill_ovf_none", overflow, 0);
        wr(8'hEE, 0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_level", level, 16);
        tick;
        chk("ovf_clear", overflow, 0);
        wr_en = 1'b1;
        wr_data = 8'hEF;
        tx_sent = 1'b1;
        tick;
        wr_en = 1'b0;
        tx_sent = 1'b0;
        chk("ovf_pop_pulse", overflow, 1);
        chk("ovf_pop_level", level, 15);
        chk("ovf_pop_full", full, 0);
        for (int i = 0; i < 15; i++) begin
            tick;
            sent;
            chk("drain_rd", tx_rd_en, 1);
        end
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);
        tick;
        sent;
        wait_idle("drain_idle");
        // reset in the middle of a transfer
        for (int i = 0; i < 6; i++) wr(8'(8'h61 + i), i == 0);
        chk("mid_level", level, 5);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1 rst_vals("reset_mid");
        tick;
        rst_n = 1'b1;
        tick;
        sent;
        for (int i = 0; i < 3; i++) begin
            chk("post_reset_rd", tx_rd_en, 0);
            tick;
        end
        chk("post_reset_busy", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
